// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/writeback/memory/branch handshake bundle for the hazard controller.
// The master side is the surrounding pipeline, the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int NREG = 16,
    parameter int RW   = 4
);
    logic            id_valid;
    logic [RW-1:0]   id_rs1;
    logic            id_rs1_used;
    logic [RW-1:0]   id_rs2;
    logic            id_rs2_used;
    logic [RW-1:0]   id_rd;
    logic            id_selWB;
    logic            id_selMEMRD;
    logic            id_selMEMWR;
    logic            id_selBRANCH;
    logic            wb_valid;
    logic [RW-1:0]   wb_rd;
    logic            mem_ready;
    logic            br_resolved;
    logic            br_taken;
    logic            issue;
    logic            stall;
    logic            flush;
    logic            mem_req;
    logic [NREG-1:0] busy_map;
    logic [1:0]      state;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_selWB, id_selMEMRD, id_selMEMWR, id_selBRANCH,
               wb_valid, wb_rd, mem_ready, br_resolved, br_taken,
        input  issue, stall, flush, mem_req, busy_map, state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_selWB, id_selMEMRD, id_selMEMWR, id_selBRANCH,
               wb_valid, wb_rd, mem_ready, br_resolved, br_taken,
        output issue, stall, flush, mem_req, busy_map, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Issue/stall controller: register scoreboard for RAW/WAW hazards, plus a
// small FSM that waits out memory accesses, unresolved branches and flushes.
module pipeline_hazard_ctrl #(
    parameter int NREG         = 16,
    parameter int RW           = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        BRWAIT  = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t           state_q;
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [NREG-1:0]  eff_busy;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_q;
    logic             mem_req_q;
    logic             hz;
    logic             issue;

    // Scoreboard view with same-cycle writeback bypassed, and the hazard it implies
    always_comb begin
        eff_busy = busy_q;
        if (bus.wb_valid) begin
            eff_busy[bus.wb_rd] = 1'b0;
        end
        hz = (bus.id_rs1_used & eff_busy[bus.id_rs1])
           | (bus.id_rs2_used & eff_busy[bus.id_rs2])
           | (bus.id_selWB    & eff_busy[bus.id_rd]);
        // Reset overrides everything, so nothing may advance while it is held.
        issue = rst_n & bus.id_valid & (state_q == RUN) & ~hz;
    end

    // Next scoreboard: writeback clears first so a same-index issue wins
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (issue && bus.id_selWB) begin
            busy_d[bus.id_rd] = 1'b1;
        end
    end

    // Control FSM with registered flush/mem_req, flush counter and scoreboard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            busy_q    <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                RUN: begin
                    // Memory takes precedence when both flags are set.
                    if (issue && (bus.id_selMEMRD || bus.id_selMEMWR)) begin
                        state_q   <= MEMWAIT;
                        mem_req_q <= 1'b1;
                    end else if (issue && bus.id_selBRANCH) begin
                        state_q <= BRWAIT;
                    end
                end
                MEMWAIT: begin
                    if (bus.mem_ready) begin
                        state_q   <= RUN;
                        mem_req_q <= 1'b0;
                    end
                end
                BRWAIT: begin
                    if (bus.br_resolved) begin
                        if (bus.br_taken) begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.issue    = issue;
    assign bus.stall    = (bus.id_valid & ~issue) | (state_q != RUN);
    assign bus.flush    = flush_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.busy_map = busy_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int NREG = 16;
    localparam int RW   = 4;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if #(.NREG(NREG), .RW(RW)) bus ();

    pipeline_hazard_ctrl #(.NREG(NREG), .RW(RW), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 run, 1 memory wait, 2 branch wait, 3 flushing
    int m_mode;
    int m_flush_left;
    bit m_busy [NREG];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_used = 0; bus.id_rs2 = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_selWB = 0; bus.id_selMEMRD = 0;
        bus.id_selMEMWR = 0; bus.id_selBRANCH = 0; bus.wb_valid = 0; bus.wb_rd = 0;
        bus.mem_ready = 0; bus.br_resolved = 0; bus.br_taken = 0;
    endtask

    task automatic instr(input int rd, input bit wb, input int rs1, input bit u1,
                         input bit memrd, input bit br);
        bus.id_valid = 1; bus.id_rd = rd[RW-1:0]; bus.id_selWB = wb;
        bus.id_rs1 = rs1[RW-1:0]; bus.id_rs1_used = u1; bus.id_rs2 = 0;
        bus.id_rs2_used = 0; bus.id_selMEMRD = memrd; bus.id_selMEMWR = 0;
        bus.id_selBRANCH = br;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        bus.id_valid = 1;
        tick(); tick();
        #2;
        checks++; if (bus.issue !== 1'b0) begin failures++; $display("FAIL reset_issue got=%b exp=0", bus.issue); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", bus.stall); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b exp=0", bus.mem_req); end
        checks++; if (bus.busy_map !== 16'h0000) begin failures++; $display("FAIL reset_busy got=%h exp=0000", bus.busy_map); end
        checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        rst_n = 1;
        bus.id_valid = 0;
        tick();
        #2;
        checks++; if ({bus.issue, bus.stall} !== 2'b00) begin failures++; $display("FAIL idle_issue_stall got=%b exp=00", {bus.issue, bus.stall}); end
    endtask

    task automatic test_raw();
        instr(8, 1, 0, 0, 0, 0);
        #2;
        checks++; if (bus.issue !== 1'b1) begin failures++; $display("FAIL raw_first_issue got=%b exp=1", bus.issue); end
        tick();
        checks++; if (bus.busy_map !== 16'h0100) begin failures++; $display("FAIL raw_busy_set got=%h exp=0100", bus.busy_map); end
        instr(0, 0, 8, 1, 0, 0);
        #2;
        checks++; if ({bus.issue, bus.stall} !== 2'b01) begin failures++; $display("FAIL raw_hold got=%b exp=01", {bus.issue, bus.stall}); end
        tick();
        bus.wb_valid = 1; bus.wb_rd = 8;
        #2;
        checks++; if ({bus.issue, bus.stall} !== 2'b10) begin failures++; $display("FAIL raw_bypass got=%b exp=10", {bus.issue, bus.stall}); end
        tick();
        checks++; if (bus.busy_map !== 16'h0000) begin failures++; $display("FAIL raw_busy_clear got=%h exp=0000", bus.busy_map); end
        idle_inputs();
    endtask

    task automatic test_collision();
        bus.wb_valid = 1; bus.wb_rd = 3;
        instr(3, 1, 0, 0, 0, 0);
        tick();
        checks++; if (bus.busy_map !== 16'h0008) begin failures++; $display("FAIL collision_set_wins got=%h exp=0008", bus.busy_map); end
        idle_inputs();
        bus.wb_valid = 1; bus.wb_rd = 3;
        tick();
        checks++; if (bus.busy_map !== 16'h0000) begin failures++; $display("FAIL collision_clear got=%h exp=0000", bus.busy_map); end
        idle_inputs();
    endtask

    task automatic test_load();
        instr(0, 0, 0, 0, 1, 0);
        tick();
        instr(1, 0, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({bus.state, bus.mem_req, bus.issue, bus.stall} !== 5'b01101) begin
                failures++; $display("FAIL load_wait%0d got=%b exp=01101", i, {bus.state, bus.mem_req, bus.issue, bus.stall});
            end
            tick();
        end
        bus.mem_ready = 1;
        #2;
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL load_ready_memreq got=%b exp=1", bus.mem_req); end
        tick();
        bus.mem_ready = 0;
        #2;
        checks++; if ({bus.state, bus.mem_req, bus.issue, bus.stall} !== 5'b00010) begin
            failures++; $display("FAIL load_resume got=%b exp=00010", {bus.state, bus.mem_req, bus.issue, bus.stall});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_branch(input bit taken);
        instr(0, 0, 0, 0, 0, 1);
        tick();
        instr(4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if ({bus.state, bus.stall, bus.flush} !== 4'b1010) begin
                failures++; $display("FAIL br_wait%0d got=%b exp=1010", i, {bus.state, bus.stall, bus.flush});
            end
            tick();
        end
        bus.br_resolved = 1; bus.br_taken = taken;
        tick();
        bus.br_resolved = 0; bus.br_taken = 0;
        if (taken) begin
            for (int i = 0; i < FC; i++) begin
                #2;
                checks++; if ({bus.state, bus.flush, bus.stall, bus.issue} !== 5'b11110) begin
                    failures++; $display("FAIL br_flush%0d got=%b exp=11110", i, {bus.state, bus.flush, bus.stall, bus.issue});
                end
                tick();
            end
        end
        #2;
        checks++; if ({bus.state, bus.flush, bus.issue} !== 4'b0001) begin
            failures++; $display("FAIL br_resume_taken%0d got=%b exp=0001", taken, {bus.state, bus.flush, bus.issue});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        instr(0, 1, 0, 0, 0, 0);
        tick();
        instr(7, 1, 0, 0, 0, 0);
        tick();
        instr(9, 0, 0, 0, 1, 0);
        tick();
        idle_inputs();
        #2;
        checks++; if ({bus.busy_map, bus.state} !== {16'h0081, 2'd1}) begin
            failures++; $display("FAIL mid_setup got=%h/%0d exp=0081/1", bus.busy_map, bus.state);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        #2;
        checks++; if ({bus.state, bus.mem_req, bus.busy_map} !== 19'd0) begin
            failures++; $display("FAIL mid_reset got=%0d/%b/%h exp=0/0/0000", bus.state, bus.mem_req, bus.busy_map);
        end
    endtask

    task automatic test_random();
        bit          e_issue, e_stall, hz;
        logic [15:0] e_busy;
        rst_n = 0; idle_inputs(); tick();
        rst_n = 1;
        m_mode = 0; m_flush_left = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.id_valid = $urandom_range(0, 3) != 0;
            bus.id_rs1 = 4'($urandom_range(0, 15)); bus.id_rs1_used = 1'($urandom);
            bus.id_rs2 = 4'($urandom_range(0, 15)); bus.id_rs2_used = 1'($urandom);
            bus.id_rd = 4'($urandom_range(0, 15)); bus.id_selWB = 1'($urandom);
            bus.id_selMEMRD = $urandom_range(0, 7) == 0; bus.id_selMEMWR = $urandom_range(0, 7) == 0;
            bus.id_selBRANCH = $urandom_range(0, 5) == 0;
            bus.wb_valid = 1'($urandom); bus.wb_rd = 4'($urandom_range(0, 15));
            bus.mem_ready = $urandom_range(0, 2) == 0;
            bus.br_resolved = $urandom_range(0, 2) == 0; bus.br_taken = 1'($urandom);
            #2;
            hz = 0;
            if (bus.id_rs1_used && m_busy[bus.id_rs1] && !(bus.wb_valid && bus.wb_rd == bus.id_rs1)) hz = 1;
            if (bus.id_rs2_used && m_busy[bus.id_rs2] && !(bus.wb_valid && bus.wb_rd == bus.id_rs2)) hz = 1;
            if (bus.id_selWB && m_busy[bus.id_rd] && !(bus.wb_valid && bus.wb_rd == bus.id_rd)) hz = 1;
            e_issue = rst_n && bus.id_valid && m_mode == 0 && !hz;
            e_stall = (bus.id_valid && !e_issue) || m_mode != 0;
            for (int i = 0; i < NREG; i++) e_busy[i] = m_busy[i];
            checks++; if (bus.issue !== e_issue) begin failures++; $display("FAIL rnd_issue c=%0d got=%b exp=%b", c, bus.issue, e_issue); end
            checks++; if (bus.stall !== e_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.stall, e_stall); end
            checks++; if (bus.flush !== (m_mode == 3)) begin failures++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, bus.flush, m_mode == 3); end
            checks++; if (bus.mem_req !== (m_mode == 1)) begin failures++; $display("FAIL rnd_memreq c=%0d got=%b exp=%b", c, bus.mem_req, m_mode == 1); end
            checks++; if (bus.state !== 2'(m_mode)) begin failures++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, bus.state, m_mode); end
            checks++; if (bus.busy_map !== e_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, bus.busy_map, e_busy); end
            tick();
            if (!rst_n) begin
                m_mode = 0; m_flush_left = 0;
                for (int i = 0; i < NREG; i++) m_busy[i] = 0;
            end else begin
                if (bus.wb_valid) m_busy[bus.wb_rd] = 0;
                if (e_issue && bus.id_selWB) m_busy[bus.id_rd] = 1;
                case (m_mode)
                    0: if (e_issue && (bus.id_selMEMRD || bus.id_selMEMWR)) m_mode = 1;
                       else if (e_issue && bus.id_selBRANCH) m_mode = 2;
                    1: if (bus.mem_ready) m_mode = 0;
                    2: if (bus.br_resolved) begin
                           if (bus.br_taken) begin m_mode = 3; m_flush_left = FC; end
                           else m_mode = 0;
                       end
                    default: begin
                        m_flush_left--;
                        if (m_flush_left == 0) m_mode = 0;
                    end
                endcase
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        #1;
        test_reset();
        test_raw();
        test_collision();
        test_load();
        test_branch(1'b1);
        test_branch(1'b0);
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
